// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation ADC controller.
// Drives the sampling switch, channel mux and CDAC trial code, and resolves one
// result bit per clock from the external comparator. Supports single-shot,
// continuous and channel-scan operation.
// Optional feature: define SAR_AVG_EN to average 2^AVG_LOG2 back-to-back
// conversions of one channel into each reported result.
module sar_adc_ctrl #(
  parameter int N          = 8,
  parameter int CHANNELS   = 4,
  parameter int SAMPLE_CYC = 2,
  parameter int AVG_LOG2   = 2,
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          start,
  input  logic          cont,
  input  logic          scan,
  input  logic [CW-1:0] ch_sel,
  input  logic          cmp,
  output logic          sample,
  output logic [CW-1:0] ch_mux,
  output logic [N-1:0]  dac_code,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  dout,
  output logic [CW-1:0] dout_ch
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SAMPLE  = 2'd1;
  localparam logic [1:0] ST_CONVERT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int BW = $clog2(N);
  localparam int SW = 4;

  if (N < 2 || N > 16) begin : g_bad_n
    $error("sar_adc_ctrl: N must be 2..16");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("sar_adc_ctrl: CHANNELS must be 1..16");
  end
  if (SAMPLE_CYC < 1 || SAMPLE_CYC > 15) begin : g_bad_sample_cyc
    $error("sar_adc_ctrl: SAMPLE_CYC must be 1..15");
  end
  if (AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_bad_avg_log2
    $error("sar_adc_ctrl: AVG_LOG2 must be 0..4");
  end

  logic [1:0]    state_q,   state_d;
  logic [SW-1:0] scnt_q,    scnt_d;
  logic [BW-1:0] bit_q,     bit_d;
  logic [N-1:0]  sar_q,     sar_d;
  logic [N-1:0]  dout_q,    dout_d;
  logic [CW-1:0] dout_ch_q, dout_ch_d;
  logic [CW-1:0] ch_q,      ch_d;

  logic [N-1:0]  trial_bit;
  logic [N-1:0]  resolved;
  logic [CW-1:0] ch_sel_clamped;
  logic [CW-1:0] ch_next;

`ifdef SAR_AVG_EN
  localparam int ACC_W = N + AVG_LOG2;
  localparam int AW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [ACC_W-1:0] acc_q,     acc_d;
  logic [AW-1:0]    avg_cnt_q, avg_cnt_d;
  logic [ACC_W-1:0] acc_sum;
  logic             avg_last;

  assign avg_last = (avg_cnt_q == AW'((1 << AVG_LOG2) - 1));
`endif

  assign trial_bit      = N'(1) << bit_q;
  assign resolved       = cmp ? (sar_q | trial_bit) : sar_q;
  assign ch_sel_clamped = (32'(ch_sel) >= 32'(CHANNELS)) ? CW'(CHANNELS - 1) : ch_sel;
  assign ch_next        = (ch_q == CW'(CHANNELS - 1)) ? '0 : ch_q + CW'(1);

  // Next-state logic: sequencing, bit resolution, result capture and channel stepping.
  // In scan mode ch_mux is not reloaded from ch_sel on start, so the scan start
  // channel is whatever a preceding scan=0 conversion (or scan step) left there.
  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    bit_d     = bit_q;
    sar_d     = sar_q;
    dout_d    = dout_q;
    dout_ch_d = dout_ch_q;
    ch_d      = ch_q;
`ifdef SAR_AVG_EN
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
    acc_sum   = acc_q + ACC_W'(resolved);
`endif

    case (state_q)
      ST_IDLE: begin
        if (en && (start || cont)) begin
          state_d = ST_SAMPLE;
          scnt_d  = '0;
          sar_d   = '0;
          if (!scan) begin
            ch_d = ch_sel_clamped;
          end
        end
      end

      ST_SAMPLE: begin
        if (scnt_q == SW'(SAMPLE_CYC - 1)) begin
          state_d = ST_CONVERT;
          bit_d   = BW'(N - 1);
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end

      ST_CONVERT: begin
        sar_d = resolved;
        if (bit_q == '0) begin
`ifdef SAR_AVG_EN
          if (avg_last) begin
            dout_d    = N'(acc_sum >> AVG_LOG2);
            dout_ch_d = ch_q;
            acc_d     = '0;
            avg_cnt_d = '0;
            state_d   = ST_DONE;
          end else begin
            acc_d     = acc_sum;
            avg_cnt_d = avg_cnt_q + AW'(1);
            state_d   = ST_SAMPLE;
            scnt_d    = '0;
            sar_d     = '0;
          end
`else
          dout_d    = resolved;
          dout_ch_d = ch_q;
          state_d   = ST_DONE;
`endif
        end else begin
          bit_d = bit_q - BW'(1);
        end
      end

      ST_DONE: begin
        if (scan) begin
          ch_d = ch_next;
        end
        if (en && cont) begin
          state_d = ST_SAMPLE;
          scnt_d  = '0;
          sar_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Disable aborts everything in flight without publishing or stepping.
    if (!en) begin
      state_d   = ST_IDLE;
      dout_d    = dout_q;
      dout_ch_d = dout_ch_q;
      ch_d      = ch_q;
`ifdef SAR_AVG_EN
      acc_d     = '0;
      avg_cnt_d = '0;
`endif
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      scnt_q    <= '0;
      bit_q     <= '0;
      sar_q     <= '0;
      dout_q    <= '0;
      dout_ch_q <= '0;
      ch_q      <= '0;
`ifdef SAR_AVG_EN
      acc_q     <= '0;
      avg_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      bit_q     <= bit_d;
      sar_q     <= sar_d;
      dout_q    <= dout_d;
      dout_ch_q <= dout_ch_d;
      ch_q      <= ch_d;
`ifdef SAR_AVG_EN
      acc_q     <= acc_d;
      avg_cnt_q <= avg_cnt_d;
`endif
    end
  end

  assign sample   = (state_q == ST_SAMPLE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign dac_code = (state_q == ST_CONVERT) ? (sar_q | trial_bit) : '0;
  assign dout     = dout_q;
  assign dout_ch  = dout_ch_q;
  assign ch_mux   = ch_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl: scoreboard bench for sar_adc_ctrl with an ideal comparator.
module tb_sar_adc_ctrl;

  localparam int N  = 8;
  localparam int SC = 2;

  logic       clk = 1'b0;
  logic       rst_n, en, start, cont, scan, cmp;
  logic [1:0] ch_sel, ch_mux, dout_ch;
  logic       sample, busy, done;
  logic [7:0] dac_code, dout;

  logic       en5, start5, cmp5, sample5, busy5, done5;
  logic [2:0] ch_sel5, ch_mux5, dout_ch5;
  logic [7:0] dac5, dout5;

  logic [7:0] chan_vin [0:3];

  always #5 clk = ~clk;

  sar_adc_ctrl #(.N(8), .CHANNELS(4), .SAMPLE_CYC(2), .AVG_LOG2(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .cont(cont), .scan(scan),
    .ch_sel(ch_sel), .cmp(cmp), .sample(sample), .ch_mux(ch_mux),
    .dac_code(dac_code), .busy(busy), .done(done), .dout(dout), .dout_ch(dout_ch)
  );

  sar_adc_ctrl #(.N(8), .CHANNELS(5), .SAMPLE_CYC(3), .AVG_LOG2(0)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .en(en5), .start(start5), .cont(1'b0), .scan(1'b0),
    .ch_sel(ch_sel5), .cmp(cmp5), .sample(sample5), .ch_mux(ch_mux5),
    .dac_code(dac5), .busy(busy5), .done(done5), .dout(dout5), .dout_ch(dout_ch5)
  );

  // Ideal comparator: the selected channel's input versus the trial code.
  assign cmp  = (chan_vin[ch_mux] >= dac_code);
  assign cmp5 = (8'h5A >= dac5);

  typedef struct packed {
    logic [7:0] code;
    logic [1:0] ch;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   prev_done_cyc = 0;
  bit   period_chk = 1'b0;
  logic [7:0] last_result = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Ideal SAR trial k: vin's bits above k, a 1 at k, zeros below.
  function automatic logic [7:0] trial(input logic [7:0] vin, input int k);
    int v;
    v = (int'(vin) & ~((1 << (k + 1)) - 1)) | (1 << k);
    return v[7:0];
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: actual dout=0x%0h ch=%0d, required no pending result", dout, dout_ch);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_dout", 32'(dout), 32'(e.code));
        check("sb_dout_ch", 32'(dout_ch), 32'(e.ch));
      end
      if (period_chk) check("done_period", 32'(cyc - prev_done_cyc), 32'd11);
      prev_done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, input string name);
    int n;
    n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: actual no done, required done within %0d cycles", name, limit);
    end
  endtask

  task automatic convert_once(input logic [7:0] vin, input logic [1:0] ch);
    chan_vin[ch] = vin;
    ch_sel = ch; scan = 0; cont = 0;
    sb_q.push_back('{code: vin, ch: ch});
    start = 1; tick(); start = 0;
    wait_done(200, "conv_timeout");
    last_result = vin;
    tick(); tick();
  endtask

  // Cycle-exact trace of one conversion: sample window, every trial, done latency.
  task automatic convert_traced(input logic [7:0] vin, input logic [1:0] ch);
    chan_vin[ch] = vin;
    ch_sel = ch; scan = 0; cont = 0;
    sb_q.push_back('{code: vin, ch: ch});
    start = 1; tick(); start = 0;
    for (int i = 0; i < SC; i++) begin
      check("sample_hi", 32'(sample), 32'd1);
      check("dac_in_sample", 32'(dac_code), 32'd0);
      check("ch_mux", 32'(ch_mux), 32'(ch));
      tick();
    end
    for (int k = N - 1; k >= 0; k--) begin
      check("sample_lo", 32'(sample), 32'd0);
      check("dac_trial", 32'(dac_code), 32'(trial(vin, k)));
      tick();
    end
    check("done_latency", 32'(done), 32'd1);
    last_result = vin;
    tick();
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int base;
    int seen;
    int n;
    logic [7:0] r;
    rst_n = 0; en = 0; start = 0; cont = 0; scan = 0; ch_sel = '0;
    en5 = 0; start5 = 0; ch_sel5 = '0;
    for (int i = 0; i < 4; i++) chan_vin[i] = '0;
    repeat (3) tick();
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dac", 32'(dac_code), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dout_ch", 32'(dout_ch), 32'd0);
    check("rst_ch_mux", 32'(ch_mux), 32'd0);
    rst_n = 1; en = 1;
    tick();

`ifdef SAR_AVG_EN
    convert_once(8'h37, 2'd1);
    convert_once(8'hC8, 2'd3);
    begin
      logic [7:0] vals [0:3];
      int sum;
      vals[0] = 8'h40; vals[1] = 8'h41; vals[2] = 8'h42; vals[3] = 8'h44;
      sum = 0;
      for (int i = 0; i < 4; i++) sum += int'(vals[i]);
      base = done_cnt;
      chan_vin[2] = vals[0]; ch_sel = 2; scan = 0; cont = 0;
      sb_q.push_back('{code: 8'(sum >> 2), ch: 2'd2});
      start = 1; tick(); start = 0;
      for (int i = 1; i < 4; i++) begin
        logic prev;
        n = 0;
        prev = sample;
        tick();
        while (!(sample && !prev) && n < 60) begin
          prev = sample;
          tick();
          n++;
        end
        if (!(sample && !prev)) begin
          checks++; errors++;
          $display("FAIL avg_sample_timeout: actual no new sample, required sample phase %0d", i);
        end
        chan_vin[2] = vals[i];
      end
      wait_done(100, "avg_timeout");
      repeat (30) tick();
      check("avg_single_done", 32'(done_cnt - base), 32'd1);
    end
`else
    convert_traced(8'hA5, 2'd2);
    convert_traced(8'h00, 2'd0);
    convert_traced(8'hFF, 2'd1);

    for (int i = 0; i < 6; i++) begin
      convert_once(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
    end

    convert_once(8'h5C, 2'd3);
    chan_vin[0] = 8'h11; chan_vin[1] = 8'h22; chan_vin[2] = 8'h33; chan_vin[3] = 8'h44;
    sb_q.push_back('{code: 8'h44, ch: 2'd3});
    sb_q.push_back('{code: 8'h11, ch: 2'd0});
    sb_q.push_back('{code: 8'h22, ch: 2'd1});
    sb_q.push_back('{code: 8'h33, ch: 2'd2});
    sb_q.push_back('{code: 8'h44, ch: 2'd3});
    scan = 1; cont = 1;
    seen = 0; n = 0;
    while (seen < 5 && n < 200) begin
      tick();
      n++;
      if (done) begin
        seen++;
        if (seen == 5) cont = 0;
      end else if (seen >= 1) begin
        period_chk = 1;
      end
    end
    if (seen < 5) begin
      checks++; errors++;
      $display("FAIL scan_timeout: actual %0d results, required 5", seen);
    end
    tick();
    period_chk = 0;
    scan = 0;
    check("scan_wrap_ch", 32'(ch_mux), 32'd0);
    check("scan_stopped", 32'(busy), 32'd0);
    last_result = 8'h44;
    tick();

    r = 8'($urandom_range(1, 254));
    chan_vin[1] = r; ch_sel = 1;
    base = done_cnt;
    start = 1; tick(); start = 0;
    repeat (5) tick();
    check("abort_busy", 32'(busy), 32'd1);
    en = 0;
    tick();
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_sample", 32'(sample), 32'd0);
    check("abort_dac", 32'(dac_code), 32'd0);
    check("abort_dout_kept", 32'(dout), 32'(last_result));
    repeat (15) tick();
    check("abort_no_done", 32'(done_cnt - base), 32'd0);
    en = 1;
    tick();

    r = 8'($urandom_range(0, 255));
    chan_vin[0] = r; ch_sel = 0;
    base = done_cnt;
    sb_q.push_back('{code: r, ch: 2'd0});
    start = 1; tick(); start = 0;
    repeat (4) tick();
    start = 1; tick(); start = 0;
    repeat (25) tick();
    check("start_busy_one_done", 32'(done_cnt - base), 32'd1);
    last_result = r;

    ch_sel = 2;
    start = 1; tick(); start = 0;
    check("pre_reset_sample", 32'(sample), 32'd1);
    rst_n = 0;
    tick();
    check("rst_mid_sample", 32'(sample), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_dac", 32'(dac_code), 32'd0);
    check("rst_mid_dout", 32'(dout), 32'd0);
    check("rst_mid_dout_ch", 32'(dout_ch), 32'd0);
    check("rst_mid_ch_mux", 32'(ch_mux), 32'd0);
    rst_n = 1;
    repeat (15) tick();

    en5 = 1; ch_sel5 = 3'd5;
    start5 = 1; tick(); start5 = 0;
    check("clamp_ch_mux", 32'(ch_mux5), 32'd4);
    n = 0;
    while (!done5 && n < 60) begin
      tick();
      n++;
    end
    check("clamp_done", 32'(done5), 32'd1);
    check("clamp_dout", 32'(dout5), 32'h5A);
    check("clamp_dout_ch", 32'(dout_ch5), 32'd4);
`endif

    repeat (5) tick();
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb_leftover: actual %0d pending results, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
